pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Consumes the per-instruction control fields produced by the ID-stage decoder.
- Keeps its own shadow copy of the EX, MEM and WB stage control state.
- Generates stall, flush/bubble and forwarding-select signals.
- Sequences the ebreak drain-and-halt.

Parameters:
DRAIN_CYCLES, 3, cycles after ebreak acceptance before halt (covers EX, MEM, WB).
FWD_EN, 1, 1 = forwarding enabled; 0 = fwd selects forced to 00 and every RAW hazard in EX/MEM stalls instead.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source 1
id_rs2  in  5  ID source 2
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  5  ID destination
id_reg_wen  in  1  ID writes the register file
id_mem_ren  in  1  ID is a load
id_ebreak  in  1  ID is ebreak
ex_redirect  in  1  branch taken or jump resolved in EX this cycle
mem_busy  in  1  data memory not ready; freeze pipeline
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID/EX inputs (ID instruction not accepted)
flush_if  out  1  squash IF/ID register contents
bubble_ex  out  1  load a NOP into ID/EX
freeze  out  1  hold all pipeline registers (mem_busy pass-through, gated)
fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 MEM ALU result, 10 WB data
fwd_b_sel  out  2  EX operand B source, same encoding
halt  out  1  pipeline halted

Behaviour:
- Reset: all shadow entries invalid, state RUN, counter 0. All outputs 0 on the cycle after rst is sampled. Reset mid-drain or mid-halt returns to RUN.
- Shadows: ex/mem/wb entries each hold {valid, rd, reg_wen, load, rs1, rs2, use_rs1, use_rs2}.
  - Each cycle without freeze: wb <= mem, mem <= ex.
  - ex <= ID fields when the ID instruction is accepted; otherwise ex <= invalid.
- Accept: id_valid & ~stall_id & ~ex_redirect & state==RUN.
- RAW match(stage, rs, use): stage.valid & stage.reg_wen & stage.rd != 0 & stage.rd == rs & use.
- Load-use (FWD_EN=1): RAW match of ID rs1/rs2 against the ex entry with ex.load=1.
  - Drives stall_if=1, stall_id=1, bubble_ex=1 for exactly 1 cycle.
  - Next cycle the load is in MEM and the consumer is still in ID. The consumer is then accepted and forwards from WB when it reaches EX.
- FWD_EN=0: any RAW match against ex or mem stalls, identical to the load-use stall, until the match clears.
- Forwarding: combinational from the ex entry versus the mem and wb entries.
  - MEM match has priority over WB.
  - A mem entry with load=1 never forwards via 01.
  - rd==0 never forwards.
  - With FWD_EN=0 both selects are 00.
- Redirect: ex_redirect=1 drives flush_if=1 and bubble_ex=1 that cycle, and squashes the ID instruction (not accepted).
  - Redirect overrides a load-use stall: stall_if=0, stall_id=0 that cycle.
- mem_busy: freeze=1, no shadow update, stall_if=stall_id=1, bubble_ex=0, flush_if=0. Redirect and load-use outputs are suppressed while frozen and re-evaluate when mem_busy drops. Forwarding selects keep their current values.
- State machine RUN -> DRAIN -> HALT:
  - RUN -> DRAIN: an accepted instruction with id_ebreak=1. The ebreak occupies EX like a NOP (reg_wen=0). Counter loads DRAIN_CYCLES.
  - DRAIN: stall_if=1, stall_id=1, bubble_ex=1. Counter decrements on each non-frozen cycle. At 0 -> HALT.
  - HALT: halt=1, stall_if=stall_id=1, bubble_ex=1. Leaves only via rst.
  - An ebreak squashed by ex_redirect in the same cycle does not enter DRAIN.
- Width rules: counter is $clog2(DRAIN_CYCLES+1) bits. Comparisons are on 5-bit register indices.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - state encoding RUN/DRAIN/HALT
  - the shadow-entry struct/bit layout
- One sub-module: hazard_raw_cmp (combinational RAW match of one source register against one shadow entry), instantiated per source/stage pair.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 back-to-back -> no stall; sub in EX sees fwd_a_sel=01.
- lw x7,0(x1) then add x8,x7,x7 -> exactly 1 cycle stall_if=stall_id=bubble_ex=1; add in EX has fwd_a_sel=fwd_b_sel=10.
- addi x0,x1,1 then add x9,x0,x0 -> no stall, both fwd_sel=00.
- Load-use stall coinciding with ex_redirect=1 -> flush_if=1, bubble_ex=1, stall_if=0; the dependent instruction is squashed.
- mem_busy held 4 cycles during a forward case -> freeze=1 throughout, shadows unchanged; forwarding identical after release.
- ebreak accepted -> 3 cycles of DRAIN with bubble_ex=1, halt=1 on the 4th cycle; rst=1 then clears halt and returns to RUN. Repeat with ebreak squashed by redirect -> halt never asserts.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forwarding-select encodings, sequencing states and the shadow-entry layout.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_wen;
    logic       load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } shadow_t;

  localparam shadow_t SHADOW_INVALID = '0;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic raw_match(input logic       valid,
                                     input logic       reg_wen,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs,
                                     input logic       src_used);
    return valid & reg_wen & (rd != 5'd0) & (rd == rs) & src_used;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and the hazard
// controller (slave): decoded ID fields in, stall/flush/forward controls out.
interface pipe_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_wen;
  logic       id_mem_ren;
  logic       id_ebreak;
  logic       ex_redirect;
  logic       mem_busy;

  logic       stall_if;
  logic       stall_id;
  logic       flush_if;
  logic       bubble_ex;
  logic       freeze;
  logic       halt;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_wen, id_mem_ren, id_ebreak, ex_redirect, mem_busy,
    input  stall_if, stall_id, flush_if, bubble_ex, freeze, halt,
           fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_wen, id_mem_ren, id_ebreak, ex_redirect, mem_busy,
    output stall_if, stall_id, flush_if, bubble_ex, freeze, halt,
           fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/pipe_hazard_ctrl_raw_cmp.sv
// Read-after-write match of one source register against one shadow stage entry.
module hazard_raw_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       valid_i,
  input  logic       reg_wen_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs_i,
  input  logic       use_i,
  output logic       match_o
);

  assign match_o = raw_match(valid_i, reg_wen_i, rd_i, rs_i, use_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: shadows the
// EX/MEM/WB control state and produces stall, flush, forwarding and halt.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter bit          FWD_EN       = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

  shadow_t          ex_q, mem_q, wb_q, ex_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0][4:0] id_rs, ex_rs;
  logic [1:0]      id_use, ex_use;
  logic [1:0]      id_hit_ex, id_hit_mem, ex_hit_mem, ex_hit_wb;
  logic [1:0][1:0] fwd_sel;

  logic load_use, raw_stall, accept;
  logic stall_if, stall_id, flush_if, bubble_ex;

  assign id_rs  = {bus.id_rs2, bus.id_rs1};
  assign id_use = {bus.id_valid & bus.id_use_rs2, bus.id_valid & bus.id_use_rs1};
  assign ex_rs  = {ex_q.rs2, ex_q.rs1};
  assign ex_use = {ex_q.valid & ex_q.use_rs2, ex_q.valid & ex_q.use_rs1};

  // Index 0 is rs1 / operand A, index 1 is rs2 / operand B.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    hazard_raw_cmp u_id_ex (
      .valid_i(ex_q.valid), .reg_wen_i(ex_q.reg_wen), .rd_i(ex_q.rd),
      .rs_i(id_rs[gi]), .use_i(id_use[gi]), .match_o(id_hit_ex[gi])
    );
    hazard_raw_cmp u_id_mem (
      .valid_i(mem_q.valid), .reg_wen_i(mem_q.reg_wen), .rd_i(mem_q.rd),
      .rs_i(id_rs[gi]), .use_i(id_use[gi]), .match_o(id_hit_mem[gi])
    );
    hazard_raw_cmp u_ex_mem (
      .valid_i(mem_q.valid), .reg_wen_i(mem_q.reg_wen), .rd_i(mem_q.rd),
      .rs_i(ex_rs[gi]), .use_i(ex_use[gi]), .match_o(ex_hit_mem[gi])
    );
    hazard_raw_cmp u_ex_wb (
      .valid_i(wb_q.valid), .reg_wen_i(wb_q.reg_wen), .rd_i(wb_q.rd),
      .rs_i(ex_rs[gi]), .use_i(ex_use[gi]), .match_o(ex_hit_wb[gi])
    );

    // A load still in MEM has no data yet; the newer MEM match still shadows WB.
    assign fwd_sel[gi] = (FWD_EN == 1'b0) ? FWD_RF :
                         ex_hit_mem[gi]   ? (mem_q.load ? FWD_RF : FWD_MEM) :
                         ex_hit_wb[gi]    ? FWD_WB : FWD_RF;
  end

  assign load_use  = (|id_hit_ex) & ex_q.load;
  assign raw_stall = (FWD_EN == 1'b1) ? load_use : ((|id_hit_ex) | (|id_hit_mem));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_if  = 1'b0;
    bubble_ex = 1'b0;

    if (bus.mem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.ex_redirect) begin
            flush_if  = 1'b1;
            bubble_ex = 1'b1;
          end else if (raw_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end else begin
            accept = bus.id_valid;
            if (accept && bus.id_ebreak) begin
              state_d = (DRAIN_CYCLES == 0) ? ST_HALT : ST_DRAIN;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = ST_HALT;
        end
        ST_HALT: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end

    ex_d = SHADOW_INVALID;
    if (accept) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = bus.id_rd;
      ex_d.reg_wen = bus.id_reg_wen & ~bus.id_ebreak;
      ex_d.load    = bus.id_mem_ren;
      ex_d.rs1     = bus.id_rs1;
      ex_d.rs2     = bus.id_rs2;
      ex_d.use_rs1 = bus.id_use_rs1;
      ex_d.use_rs2 = bus.id_use_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= SHADOW_INVALID;
      mem_q   <= SHADOW_INVALID;
      wb_q    <= SHADOW_INVALID;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!bus.mem_busy) begin
        ex_q  <= ex_d;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
    end
  end

  // Source fields of the older stages are carried only to keep one entry layout.
  logic unused_shadow_bits;
  assign unused_shadow_bits = ^{mem_q.rs1, mem_q.rs2, mem_q.use_rs1, mem_q.use_rs2,
                                wb_q.load, wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2};

  assign bus.stall_if  = stall_if;
  assign bus.stall_id  = stall_id;
  assign bus.flush_if  = flush_if;
  assign bus.bubble_ex = bubble_ex;
  assign bus.freeze    = bus.mem_busy;
  assign bus.halt      = (state_q == ST_HALT);
  assign bus.fwd_a_sel = fwd_sel[0];
  assign bus.fwd_b_sel = fwd_sel[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (forwarding on / off) share one
// stimulus stream and are checked every cycle against an instruction-level model.
module tb_pipe_hazard_ctrl;

  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus0();
  pipe_hazard_ctrl_if bus1();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .FWD_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .FWD_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  logic       i_v = 0, i_u1 = 0, i_u2 = 0, i_wen = 0, i_ld = 0, i_eb = 0, i_red = 0, i_busy = 0;
  logic [4:0] i_rd = 0, i_rs1 = 0, i_rs2 = 0;

  int n_vec = 0;
  int n_bad = 0;

  // Instruction-level model: pl[n][0..2] = instruction now in EX, MEM, WB.
  typedef struct {
    bit       v;
    bit [4:0] rd, rs1, rs2;
    bit       wen, ld, u1, u2;
  } ins_t;

  ins_t pl   [2][3];
  int   mode [2];   // 0 running, 1 draining, 2 halted
  int   left [2];

  task automatic apply();
    bus0.id_valid = i_v;   bus1.id_valid = i_v;
    bus0.id_rs1 = i_rs1;   bus1.id_rs1 = i_rs1;
    bus0.id_rs2 = i_rs2;   bus1.id_rs2 = i_rs2;
    bus0.id_use_rs1 = i_u1; bus1.id_use_rs1 = i_u1;
    bus0.id_use_rs2 = i_u2; bus1.id_use_rs2 = i_u2;
    bus0.id_rd = i_rd;     bus1.id_rd = i_rd;
    bus0.id_reg_wen = i_wen; bus1.id_reg_wen = i_wen;
    bus0.id_mem_ren = i_ld;  bus1.id_mem_ren = i_ld;
    bus0.id_ebreak = i_eb;   bus1.id_ebreak = i_eb;
    bus0.ex_redirect = i_red; bus1.ex_redirect = i_red;
    bus0.mem_busy = i_busy;  bus1.mem_busy = i_busy;
  endtask

  function automatic bit writes(ins_t s, bit [4:0] r, bit u);
    return s.v && s.wen && (r != 5'd0) && (s.rd == r) && u;
  endfunction

  function automatic bit hazard(int n);
    bit dex, dmem;
    dex  = writes(pl[n][0], i_rs1, i_u1) || writes(pl[n][0], i_rs2, i_u2);
    dmem = writes(pl[n][1], i_rs1, i_u1) || writes(pl[n][1], i_rs2, i_u2);
    if (!i_v) return 1'b0;
    return (n == 0) ? (dex && pl[n][0].ld) : (dex || dmem);
  endfunction

  function automatic bit [1:0] fwd_src(int n, bit [4:0] r, bit u);
    if (n != 0 || !pl[n][0].v) return 2'b00;
    if (writes(pl[n][1], r, u)) return pl[n][1].ld ? 2'b00 : 2'b01;
    if (writes(pl[n][2], r, u)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [9:0] pk(bit sif, bit sid, bit fl, bit bub, bit frz, bit hlt,
                                    bit [1:0] fa, bit [1:0] fb);
    return {sif, sid, fl, bub, frz, hlt, fa, fb};
  endfunction

  function automatic logic [9:0] expect_outs(int n);
    bit sif = 0, sid = 0, fl = 0, bub = 0;
    if (i_busy) begin
      sif = 1; sid = 1;
    end else if (mode[n] != 0) begin
      sif = 1; sid = 1; bub = 1;
    end else if (i_red) begin
      fl = 1; bub = 1;
    end else if (hazard(n)) begin
      sif = 1; sid = 1; bub = 1;
    end
    return pk(sif, sid, fl, bub, i_busy, mode[n] == 2,
              fwd_src(n, pl[n][0].rs1, pl[n][0].u1),
              fwd_src(n, pl[n][0].rs2, pl[n][0].u2));
  endfunction

  function automatic logic [9:0] dut_outs(int n);
    if (n == 0)
      return {bus0.stall_if, bus0.stall_id, bus0.flush_if, bus0.bubble_ex,
              bus0.freeze, bus0.halt, bus0.fwd_a_sel, bus0.fwd_b_sel};
    return {bus1.stall_if, bus1.stall_id, bus1.flush_if, bus1.bubble_ex,
            bus1.freeze, bus1.halt, bus1.fwd_a_sel, bus1.fwd_b_sel};
  endfunction

  task automatic cmp(string name, logic [9:0] act, logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {sif,sid,fl,bub,frz,halt,fa,fb}=%b expected %b",
               name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int s = 0; s < 3; s++) pl[n][s] = '{default: 0};
      mode[n] = 0;
      left[n] = 0;
    end
  endtask

  task automatic model_step();
    for (int n = 0; n < 2; n++) begin
      bit   acc;
      ins_t nw;
      if (i_busy) continue;
      acc = (mode[n] == 0) && i_v && !i_red && !hazard(n);
      nw  = '{default: 0};
      if (acc) nw = '{v: 1, rd: i_rd, rs1: i_rs1, rs2: i_rs2,
                      wen: i_wen && !i_eb, ld: i_ld, u1: i_u1, u2: i_u2};
      pl[n][2] = pl[n][1];
      pl[n][1] = pl[n][0];
      pl[n][0] = nw;
      if (mode[n] == 1) begin
        left[n]--;
        if (left[n] == 0) mode[n] = 2;
      end else if (acc && i_eb) begin
        mode[n] = 1;
        left[n] = DRAIN;
      end
    end
  endtask

  // Compare on the falling edge, then advance the model across the next rising edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
      end else begin
        for (int n = 0; n < 2; n++)
          cmp($sformatf("model_dut%0d", n), dut_outs(n), expect_outs(n));
        model_step();
      end
    end
  end

  task automatic drive(input bit v, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit u1, input bit u2, input bit wen, input bit ld, input bit eb,
                       input bit red, input bit busy);
    @(posedge clk); #1;
    i_v = v; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_u1 = u1; i_u2 = u2;
    i_wen = wen; i_ld = ld; i_eb = eb; i_red = red; i_busy = busy;
    apply();
    #1;
  endtask

  task automatic idle(input bit busy = 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy);
  endtask

  task automatic lit(string name, int n, logic [9:0] exp);
    cmp(name, dut_outs(n), exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    i_v = 0; i_rd = 0; i_rs1 = 0; i_rs2 = 0; i_u1 = 0; i_u2 = 0;
    i_wen = 0; i_ld = 0; i_eb = 0; i_red = 0; i_busy = 0;
    apply();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    lit("reset_dut0", 0, '0);
    lit("reset_dut1", 1, '0);
  endtask

  initial begin
    logic [9:0] stall_v, zero_v;
    stall_v = pk(1, 1, 0, 1, 0, 0, 2'b00, 2'b00);
    zero_v  = '0;
    apply();
    do_reset();

    // add x5,x1,x2 ; sub x6,x5,x3
    drive(1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 0);  lit("alu_add_issue", 0, zero_v);
    drive(1, 6, 5, 3, 1, 1, 1, 0, 0, 0, 0);  lit("alu_sub_nostall", 0, zero_v);
    lit("alu_sub_nofwd_stall", 1, stall_v);
    idle();                                  lit("alu_fwd_mem", 0, pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00));

    // lw x7,0(x1) ; add x8,x7,x7
    do_reset();
    drive(1, 7, 1, 0, 1, 0, 1, 1, 0, 0, 0);  lit("lw_issue", 0, zero_v);
    drive(1, 8, 7, 7, 1, 1, 1, 0, 0, 0, 0);  lit("loaduse_stall", 0, stall_v);
    drive(1, 8, 7, 7, 1, 1, 1, 0, 0, 0, 0);  lit("loaduse_release", 0, zero_v);
    lit("loaduse_nofwd_still_stalled", 1, stall_v);
    idle();                                  lit("loaduse_fwd_wb", 0, pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b10));

    // addi x0,x1,1 ; add x9,x0,x0
    do_reset();
    drive(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    drive(1, 9, 0, 0, 1, 1, 1, 0, 0, 0, 0);  lit("x0_nostall", 0, zero_v);
    lit("x0_nostall_nofwd", 1, zero_v);
    idle();                                  lit("x0_nofwd", 0, zero_v);

    // load-use coinciding with redirect
    do_reset();
    drive(1, 7, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    drive(1, 8, 7, 7, 1, 1, 1, 0, 0, 1, 0);  lit("redirect_over_loaduse", 0, pk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00));
    idle();                                  lit("redirect_squash_ex", 0, zero_v);
    idle();                                  lit("redirect_squash_wb", 0, zero_v);

    // mem_busy held during a forward case
    do_reset();
    drive(1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 0);
    drive(1, 6, 5, 3, 1, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      lit($sformatf("freeze_c%0d", k), 0, pk(1, 1, 0, 0, 1, 0, 2'b01, 2'b00));
    end
    idle();                                  lit("freeze_release_fwd", 0, pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
    idle();                                  lit("freeze_after", 0, zero_v);

    // ebreak drain and halt, then reset, then squashed ebreak
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  lit("ebreak_accept", 0, zero_v);
    for (int k = 0; k < DRAIN; k++) begin
      idle();
      lit($sformatf("drain_c%0d", k), 0, stall_v);
    end
    for (int k = 0; k < 2; k++) begin
      idle();
      lit($sformatf("halt_c%0d", k), 0, pk(1, 1, 0, 1, 0, 1, 2'b00, 2'b00));
      lit($sformatf("halt_nofwd_c%0d", k), 1, pk(1, 1, 0, 1, 0, 1, 2'b00, 2'b00));
    end
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);  lit("ebreak_squashed", 0, pk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00));
    for (int k = 0; k < 6; k++) begin
      idle();
      lit($sformatf("no_halt_c%0d", k), 0, zero_v);
    end

    // randomized traffic over a small register set to make hazards frequent
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst    = ($urandom_range(0, 99) == 0);
      i_v    = ($urandom_range(0, 9) < 7);
      i_rd   = 5'($urandom_range(0, 3));
      i_rs1  = 5'($urandom_range(0, 3));
      i_rs2  = 5'($urandom_range(0, 3));
      i_u1   = ($urandom_range(0, 3) != 0);
      i_u2   = ($urandom_range(0, 1) != 0);
      i_wen  = ($urandom_range(0, 3) != 0);
      i_ld   = ($urandom_range(0, 9) < 3);
      i_eb   = ($urandom_range(0, 99) == 0);
      i_red  = ($urandom_range(0, 9) == 0);
      i_busy = ($urandom_range(0, 9) == 0);
      apply();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
